// File: rtl/uart_bram_tx_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_bram_tx_reader_if
// Purpose  : Control, BRAM read port and status bundle for the UART Tx reader.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_bram_tx_reader_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  Start;
  logic [ADDR_WIDTH-1:0] StartAddr;
  logic [ADDR_WIDTH:0]   Count;
  logic                  BramEn;
  logic [ADDR_WIDTH-1:0] BramAddr;
  logic [7:0]            BramDout;
  logic                  Tx;
  logic                  Busy;
  logic                  TxByteDone;
  logic                  Done;
  logic [ADDR_WIDTH:0]   ByteIndex;

  // master: controller plus BRAM side; slave: the Tx reader itself
  modport master (
    output Start, StartAddr, Count, BramDout,
    input  BramEn, BramAddr, Tx, Busy, TxByteDone, Done, ByteIndex
  );

  modport slave (
    input  Start, StartAddr, Count, BramDout,
    output BramEn, BramAddr, Tx, Busy, TxByteDone, Done, ByteIndex
  );
endinterface
`default_nettype wire

// File: rtl/uart_bram_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : uart_bram_tx_reader
// Purpose  : Reads a run of bytes from BRAM and sends each as 8N1, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bram_tx_reader #(
  parameter int CLOCKS_PER_BIT = 10417,
  parameter int ADDR_WIDTH     = 3,
  parameter int READ_LATENCY   = 1
) (
  input logic                  Clk,
  input logic                  ResetN,
  uart_bram_tx_reader_if.slave bus
);

  localparam int                    c_BAUD_WIDTH = $clog2(CLOCKS_PER_BIT);
  localparam logic [c_BAUD_WIDTH-1:0] c_BAUD_LAST = c_BAUD_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH:0]   c_DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [1:0]            c_WAIT_LAST  = 2'(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_START_BIT = 3'd2,
    S_DATA      = 3'd3,
    S_STOP_BIT  = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_tx;
  logic                    r_busy;
  logic                    r_bram_en;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH:0]     r_byte_index;
  logic [ADDR_WIDTH:0]     r_count;
  logic [7:0]              r_shift;
  logic [c_BAUD_WIDTH-1:0] r_baud;
  logic [2:0]              r_bit;
  logic [1:0]              r_wait;
  logic                    r_tx_byte_done;
  logic                    r_done;

  logic [ADDR_WIDTH:0]     w_count_clamped;
  logic [ADDR_WIDTH:0]     w_next_index;
  logic                    w_bit_end;

  assign w_count_clamped = (bus.Count > c_DEPTH) ? c_DEPTH : bus.Count;
  assign w_next_index    = r_byte_index + 1'b1;
  assign w_bit_end       = (r_baud == c_BAUD_LAST);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state        <= S_IDLE;
      r_tx           <= 1'b1;
      r_busy         <= 1'b0;
      r_bram_en      <= 1'b0;
      r_addr         <= '0;
      r_byte_index   <= '0;
      r_count        <= '0;
      r_shift        <= '0;
      r_baud         <= '0;
      r_bit          <= '0;
      r_wait         <= '0;
      r_tx_byte_done <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_bram_en      <= 1'b0;
      r_tx_byte_done <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Busy while idle only happens for an empty run: finish it here
          if (r_busy) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else if (bus.Start) begin
            r_busy       <= 1'b1;
            r_addr       <= bus.StartAddr;
            r_count      <= w_count_clamped;
            r_byte_index <= '0;
            r_wait       <= '0;
            if (w_count_clamped != '0) begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (r_wait == 2'd0) begin
            r_bram_en <= 1'b1;
            r_wait    <= 2'd1;
          end else if (r_wait == c_WAIT_LAST) begin
            r_shift <= bus.BramDout;
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= S_START_BIT;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_START_BIT: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP_BIT;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP_BIT: begin
          if (w_bit_end) begin
            r_baud         <= '0;
            r_tx_byte_done <= 1'b1;
            r_byte_index   <= w_next_index;
            r_addr         <= r_addr + 1'b1;
            // Issue the next read right away so the gap is only the read latency
            if (w_next_index < r_count) begin
              r_bram_en <= 1'b1;
              r_wait    <= 2'd1;
              r_state   <= S_FETCH;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Tx         = r_tx;
  assign bus.Busy       = r_busy;
  assign bus.BramEn     = r_bram_en;
  assign bus.BramAddr   = r_addr;
  assign bus.TxByteDone = r_tx_byte_done;
  assign bus.Done       = r_done;
  assign bus.ByteIndex  = r_byte_index;

endmodule
`default_nettype wire

// File: tb/tb_uart_bram_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_bram_tx_reader
// Purpose  : Directed and randomized runs checked against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bram_tx_reader;

  localparam int C     = 16;
  localparam int RL    = 1;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int F     = RL + 2;          // accept edge -> first start bit
  localparam int P     = 10 * C + RL + 1; // start bit to next start bit

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_bram_tx_reader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_bram_tx_reader #(
    .CLOCKS_PER_BIT(C),
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (RL)
  ) dut (
    .Clk   (clk),
    .ResetN(rst_n),
    .bus   (bus)
  );

  // BRAM with noise on the data bus outside the valid window
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_pipe [RL];
  logic [RL-1:0] vld_pipe;
  logic [7:0]    noise;
  always @(posedge clk) begin
    noise <= 8'($urandom);
    if (bus.BramEn) rd_pipe[0] <= mem[bus.BramAddr];
    vld_pipe[0] <= bus.BramEn;
    for (int i = 1; i < RL; i++) begin
      rd_pipe[i]  <= rd_pipe[i-1];
      vld_pipe[i] <= vld_pipe[i-1];
    end
  end
  assign bus.BramDout = vld_pipe[RL-1] ? rd_pipe[RL-1] : noise;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else begin
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      if (n_tot - n_pass >= 200) begin
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
      end
    end
  endtask

  // Run model: outputs are a function of edges elapsed since the accepted Start
  logic       m_have  = 1'b0;
  logic       m_valid = 1'b0;
  int         m_t, m_end, m_n, m_sa, m_k;
  logic [7:0] m_bytes [DEPTH];

  function automatic int clamp_n(input int c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  function automatic int end_of(input int n);
    return (n == 0) ? 1 : F + (n - 1) * P + 10 * C;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_have  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_have && m_t < m_end) begin
      m_t <= m_t + 1;
    end else if (bus.Start === 1'b1) begin
      m_have <= 1'b1;
      m_t    <= 0;
      m_k    <= cyc + 1;
      m_sa   <= int'(bus.StartAddr);
      m_n    <= clamp_n(int'(bus.Count));
      m_end  <= end_of(clamp_n(int'(bus.Count)));
      for (int j = 0; j < DEPTH; j++) m_bytes[j] <= mem[(int'(bus.StartAddr) + j) % DEPTH];
    end else if (m_have) begin
      m_t <= m_end + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic e_tx, e_busy, e_done, e_tbd, e_en;
    int   e_idx, e_addr, s, b;
    if (m_valid) begin
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_tbd = 1'b0; e_en = 1'b0;
      e_idx = 0; e_addr = 0;
      if (m_have) begin
        e_busy = (m_t < m_end);
        e_done = (m_t == m_end);
        for (int j = 0; j < m_n; j++) begin
          s = F + j * P;
          if (m_t >= s + 10 * C) e_idx++;
          if (m_t == s + 10 * C) e_tbd = 1'b1;
          if (m_t >= s && m_t < s + 10 * C) begin
            b = (m_t - s) / C;
            e_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_bytes[j][b-1];
          end
          if (m_t == s - RL - 1) begin
            e_en   = 1'b1;
            e_addr = (m_sa + j) % DEPTH;
          end
        end
      end
      chk("tx", bus.Tx, e_tx);
      chk("busy", bus.Busy, e_busy);
      chk("done", bus.Done, e_done);
      chk("tx_byte_done", bus.TxByteDone, e_tbd);
      chk("byte_index", bus.ByteIndex, e_idx);
      chk("bram_en", bus.BramEn, e_en);
      if (!m_have || e_en) chk("bram_addr", bus.BramAddr, e_addr);
    end
  end

  // Host-side UART receiver sampling at mid-bit
  logic [7:0] rx_q [$];
  int         fall_q [$];
  logic [9:0] last_pat;
  logic       rx_prev = 1'b1;
  initial begin : uart_rx
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (rst_n && rx_prev && !bus.Tx) begin
        fall_q.push_back(cyc);
        repeat (C / 2) @(negedge clk);
        bits[0] = bus.Tx;
        for (int k = 1; k < 10; k++) begin
          repeat (C) @(negedge clk);
          bits[k] = bus.Tx;
        end
        rx_q.push_back(bits[8:1]);
        last_pat = bits;
      end
      rx_prev = bus.Tx;
    end
  end

  int addr_q [$];
  always @(negedge clk) if (rst_n && bus.BramEn) addr_q.push_back(int'(bus.BramAddr));

  int done_idx;
  int done_tbd;

  task automatic clear_logs();
    rx_q.delete(); fall_q.delete(); addr_q.delete();
  endtask

  task automatic pulse_start(input int a, input int n);
    @(negedge clk);
    bus.Start     = 1'b1;
    bus.StartAddr = AW'(a);
    bus.Count     = (AW+1)'(n);
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.Done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_tot++;
      $display("FAIL done_timeout at cycle %0d: got no Done, expected Done within %0d cycles", cyc, budget);
    end
    done_idx = int'(bus.ByteIndex);
    done_tbd = int'(bus.TxByteDone);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_bytes(input string nm, input int a, input int n);
    chk({nm, "_count"}, rx_q.size(), n);
    for (int j = 0; j < n; j++)
      chk({nm, "_byte"}, (j < rx_q.size()) ? 32'(rx_q[j]) : 32'hDEAD, mem[(a + j) % DEPTH]);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected end of test", cyc);
    n_tot++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    logic [7:0] exp_wrap [8];
    int         exp_addr [8];
    int         a, n;
    exp_wrap = '{8'h67, 8'h68, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    exp_addr = '{6, 7, 0, 1, 2, 3, 4, 5};
    bus.Start = 1'b0; bus.StartAddr = '0; bus.Count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h61 + i);

    repeat (3) @(negedge clk);
    chk("reset_tx", bus.Tx, 1);
    chk("reset_busy", bus.Busy, 0);
    chk("reset_bram_en", bus.BramEn, 0);
    chk("reset_done", bus.Done, 0);
    chk("reset_byte_index", bus.ByteIndex, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x61
    clear_logs();
    pulse_start(0, 1);
    wait_done(P + 50);
    chk("single_value", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 8'h61);
    chk("single_pattern", last_pat, 10'b1011000010);
    chk("single_first_fall", (fall_q.size() > 0) ? fall_q[0] - m_k : -1, 3);
    chk("single_done_with_tbd", done_tbd, 1);

    // Full run with address wrap
    clear_logs();
    pulse_start(6, 8);
    wait_done(8 * P + 50);
    chk("wrap_count", rx_q.size(), 8);
    for (int j = 0; j < 8; j++) begin
      chk("wrap_byte", (j < rx_q.size()) ? 32'(rx_q[j]) : 32'hDEAD, exp_wrap[j]);
      chk("wrap_addr", (j < addr_q.size()) ? addr_q[j] : -1, exp_addr[j]);
    end
    chk("wrap_index_at_done", done_idx, 8);
    chk("wrap_frame_period", (fall_q.size() > 1) ? fall_q[1] - fall_q[0] : -1, 162);

    // Empty run
    clear_logs();
    pulse_start(3, 0);
    wait_done(10);
    chk("zero_frames", rx_q.size(), 0);
    chk("zero_reads", addr_q.size(), 0);

    // Count above depth is clamped
    clear_logs();
    pulse_start(1, 12);
    wait_done(8 * P + 50);
    chk_bytes("clamp", 1, 8);

    // Start during byte 2 is ignored
    clear_logs();
    pulse_start(0, 4);
    repeat (P + 50) @(negedge clk);
    pulse_start(5, 1);
    wait_done(4 * P + 50);
    chk_bytes("ignored_start", 0, 4);

    // Reset in data bit 4 of byte 1
    clear_logs();
    pulse_start(0, 3);
    repeat (F + P + 5 * C + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_tx", bus.Tx, 1);
    chk("midreset_done", bus.Done, 0);
    rst_n = 1'b1;
    repeat (12 * C) @(negedge clk);
    clear_logs();
    pulse_start(2, 2);
    wait_done(2 * P + 50);
    chk_bytes("after_reset", 2, 2);

    // Randomized runs with stray Start pulses
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 15);
      clear_logs();
      pulse_start(a, n);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10 * C)) @(negedge clk);
        pulse_start($urandom_range(0, DEPTH - 1), $urandom_range(1, 15));
      end
      wait_done(8 * P + 100);
      chk_bytes("random", a, clamp_n(n));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
